// File: rtl/lzc_norm_stage.sv
// lzc_norm_stage: two-stage valid/ready leading-zero count front-end for a left shifter; NORM_STATS_EN adds saturating norm_cnt
module lzc_norm_stage #(
  parameter int WIDTH = 8,
  localparam int SHIFT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   norm_data,
  output logic [SHIFT_W-1:0] norm_shift,
`ifdef NORM_STATS_EN
  output logic               norm_zero,
  output logic [15:0]        norm_cnt
`else
  output logic               norm_zero
`endif
);
  logic               s1_valid;
  logic [WIDTH-1:0]   s1_data;
  logic               s1_en;
  logic               s2_en;
  logic [SHIFT_W-1:0] lz;
  always_comb begin
    s2_en = !out_valid || out_ready;
    s1_en = !s1_valid || s2_en;
    in_ready = s1_en;
  end
  always_comb begin
    lz = '0;
    for (int i = 0; i < WIDTH; i++) lz = s1_data[i] ? SHIFT_W'(WIDTH - 1 - i) : lz;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_data    <= '0;
      out_valid  <= 1'b0;
      norm_data  <= '0;
      norm_shift <= '0;
      norm_zero  <= 1'b0;
    end else begin
      if (s1_en) begin
        s1_valid <= in_valid;
        if (in_valid) s1_data <= in_data;
      end
      if (s2_en) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          norm_data  <= s1_data;
          norm_shift <= lz;
          norm_zero  <= s1_data == '0;
        end
      end
    end
  end
`ifdef NORM_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) norm_cnt <= '0;
    else if (in_valid && in_ready && norm_cnt != 16'hFFFF) norm_cnt <= norm_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_lzc_norm_stage.sv
// tb_lzc_norm_stage: directed vector and handshake-sequence checks for lzc_norm_stage
module tb_lzc_norm_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [7:0] in_data = '0;
  logic in_ready, out_valid, norm_zero;
  logic [7:0] norm_data, dout;
  logic [2:0] norm_shift;
  logic in_valid12 = 1'b0;
  logic [11:0] in_data12 = '0;
  logic in_ready12, out_valid12, norm_zero12;
  logic [11:0] norm_data12, dout12;
  logic [3:0] norm_shift12;
`ifdef NORM_STATS_EN
  logic [15:0] norm_cnt, norm_cnt12;
`endif
  assign dout = norm_data << norm_shift;
  assign dout12 = norm_data12 << norm_shift12;
  lzc_norm_stage #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .norm_data(norm_data), .norm_shift(norm_shift),
`ifdef NORM_STATS_EN
    .norm_cnt(norm_cnt),
`endif
    .norm_zero(norm_zero)
  );
  lzc_norm_stage #(.WIDTH(12)) u12 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid12), .in_ready(in_ready12), .in_data(in_data12),
    .out_valid(out_valid12), .out_ready(1'b1), .norm_data(norm_data12), .norm_shift(norm_shift12),
`ifdef NORM_STATS_EN
    .norm_cnt(norm_cnt12),
`endif
    .norm_zero(norm_zero12)
  );
  typedef struct {
    logic [7:0] d;
    logic [2:0] sh;
    logic       z;
    logic [7:0] o;
  } vec_t;
  typedef struct {
    logic [11:0] d;
    logic [3:0]  sh;
    logic [11:0] o;
  } vec12_t;
  vec_t   vt[10];
  vec12_t vt12[4];
  int total = 0;
  int bad = 0;
  logic [7:0] q[$];
  logic [7:0] words[17];
  function automatic int ref_lz(logic [7:0] d);
    int n = 0;
    if (d == 8'h00) return 0;
    while (!d[7]) begin
      d = d << 1;
      n++;
    end
    return n;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic step(input bit v, input logic [7:0] d, input bit ordy, output bit acc, output bit got);
    logic [7:0] e;
    logic [2:0] es;
    in_valid = v;
    in_data = d;
    out_ready = ordy;
    #1;
    got = out_valid && out_ready;
    if (got) begin
      if (q.size() == 0) chk("unexpected_out", {norm_data, 1'b1}, 9'h0);
      else begin
        e = q.pop_front();
        es = 3'(ref_lz(e));
        chk("stream_word", {norm_data, norm_shift, norm_zero}, {e, es, e == 8'h00});
      end
    end
    acc = v && in_ready;
    if (acc) q.push_back(d);
    @(negedge clk);
  endtask
  initial begin
    bit acc, got;
    int n_in, n_out, first, last;
    vt[0] = '{8'h16, 3'd3, 1'b0, 8'hB0};
    vt[1] = '{8'h80, 3'd0, 1'b0, 8'h80};
    vt[2] = '{8'h01, 3'd7, 1'b0, 8'h80};
    vt[3] = '{8'h00, 3'd0, 1'b1, 8'h00};
    vt[4] = '{8'h40, 3'd1, 1'b0, 8'h80};
    vt[5] = '{8'hFF, 3'd0, 1'b0, 8'hFF};
    vt[6] = '{8'h03, 3'd6, 1'b0, 8'hC0};
    vt[7] = '{8'h20, 3'd2, 1'b0, 8'h80};
    vt[8] = '{8'h0F, 3'd4, 1'b0, 8'hF0};
    vt[9] = '{8'h08, 3'd4, 1'b0, 8'h80};
    vt12[0] = '{12'h001, 4'd11, 12'h800};
    vt12[1] = '{12'h800, 4'd0, 12'h800};
    vt12[2] = '{12'h00F, 4'd8, 12'hF00};
    vt12[3] = '{12'h000, 4'd0, 12'h000};
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_outputs", {norm_data, norm_shift, norm_zero}, 0);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data = vt[i].d;
      out_ready = 1'b1;
      #1;
      chk("vec_in_ready", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      in_data = '0;
      #1;
      chk("vec_not_early", out_valid, 0);
      @(negedge clk);
      chk("vec_out_valid", out_valid, 1);
      chk("vec_shift", norm_shift, vt[i].sh);
      chk("vec_zero", norm_zero, vt[i].z);
      chk("vec_data", norm_data, vt[i].d);
      chk("vec_dout", dout, vt[i].o);
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      in_valid12 = 1'b1;
      in_data12 = vt12[i].d;
      @(negedge clk);
      in_valid12 = 1'b0;
      @(negedge clk);
      chk("w12_valid", out_valid12, 1);
      chk("w12_shift", norm_shift12, vt12[i].sh);
      chk("w12_zero", norm_zero12, vt12[i].d == 12'h000);
      chk("w12_dout", dout12, vt12[i].o);
      @(negedge clk);
    end
    q.delete();
    for (int i = 0; i < 16; i++) words[i] = 8'($urandom);
    words[3] = 8'h00;
    words[7] = 8'h01;
    words[16] = '0;
    n_in = 0;
    n_out = 0;
    first = -1;
    last = -1;
    for (int c = 0; c < 40 && n_out < 16; c++) begin
      step(n_in < 16, words[n_in], 1'b1, acc, got);
      if (acc) n_in++;
      if (got) begin
        if (first < 0) first = c;
        last = c;
        n_out++;
      end
    end
    chk("stream_count", n_out, 16);
    chk("stream_first", first, 2);
    chk("stream_last", last, 17);
    chk("stream_drained", q.size(), 0);
    q.delete();
    for (int i = 0; i < 6; i++) words[i] = 8'h11 * (i + 1);
    words[6] = '0;
    n_in = 0;
    n_out = 0;
    for (int c = 0; c < 5; c++) begin
      step(1'b1, words[n_in], 1'b0, acc, got);
      if (acc) n_in++;
      if (c >= 2) chk("bp_hold", {out_valid, norm_data}, {1'b1, words[0]});
    end
    chk("bp_accepts", n_in, 2);
    chk("bp_in_ready", in_ready, 0);
    for (int c = 0; c < 20 && n_out < 6; c++) begin
      step(n_in < 6, words[n_in], 1'b1, acc, got);
      if (acc) n_in++;
      if (got) n_out++;
    end
    chk("bp_count", n_out, 6);
    chk("bp_drained", q.size(), 0);
    step(1'b1, 8'hA5, 1'b0, acc, got);
    step(1'b1, 8'h3C, 1'b0, acc, got);
    in_valid = 1'b0;
    chk("mid_full", {out_valid, in_ready}, 2'b10);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_outputs", {norm_data, norm_shift, norm_zero}, 0);
    rst_n = 1'b1;
    q.delete();
    #1;
    chk("mid_in_ready", in_ready, 1);
    in_valid = 1'b1;
    in_data = 8'h24;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("mid_not_early", out_valid, 0);
    @(negedge clk);
    chk("mid_new_word", {out_valid, norm_data, norm_shift}, {1'b1, 8'h24, 3'd2});
    @(negedge clk);
`ifdef NORM_STATS_EN
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("cnt_reset", norm_cnt, 0);
    in_valid = 1'b1;
    in_data = 8'h5A;
    repeat (10) @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("cnt_ten", norm_cnt, 10);
    in_valid = 1'b1;
    repeat (65530) @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("cnt_saturate", norm_cnt, 16'hFFFF);
    @(negedge clk);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
